riscv_decode: RTL

Decode stage of the five-stage pipelined RV32I core; sits directly downstream of the fetch stage and consumes its D-stage instruction, PC and PC+4. Holds the 32x32 integer register file (written by the writeback stage), decodes opcode/funct fields into control signals, and expands the immediate. All results are registered into the D/E pipeline register and presented to the execute stage.

---
 rtl/riscv_decode_pkg.sv | 99 +++++++++
 rtl/riscv_regfile.sv | 39 +++
 rtl/riscv_decode.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/riscv_decode_pkg.sv
// Shared types, encodings and helpers for the RV32I decode stage.
package riscv_decode_pkg;

  localparam int unsigned Xlen  = 32;
  localparam int unsigned NReg  = 32;
  localparam int unsigned RegAw = $clog2(NReg);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluSll  = 4'b0010,
    AluSlt  = 4'b0011,
    AluSltu = 4'b0100,
    AluXor  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluOr   = 4'b1000,
    AluAnd  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SrcARd1  = 2'b00,
    SrcAPc   = 2'b01,
    SrcAZero = 2'b10
  } src_a_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        jalr;
    result_src_e result_src;
    src_a_e      alu_src_a;
    logic        alu_src_b;
    alu_op_e     alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            ctrl;
    logic [Xlen-1:0]  rd1;
    logic [Xlen-1:0]  rd2;
    logic [Xlen-1:0]  imm;
    logic [Xlen-1:0]  pc;
    logic [Xlen-1:0]  pc_plus_4;
    logic [RegAw-1:0] rs1;
    logic [RegAw-1:0] rs2;
    logic [RegAw-1:0] rd;
    logic [2:0]       funct3;
  } de_t;

  function automatic logic [Xlen-1:0] imm_expand(input logic [31:0] instr, input imm_sel_e sel);
    logic [Xlen-1:0] imm;
    unique case (sel)
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm = {instr[31:12], 12'b0};
      ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

  // funct7[5] selects SUB only for register-register ops; it selects SRA for both forms.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic f7b5,
                                             input logic is_op);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_op && f7b5) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = f7b5 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32-entry integer register file: x0 hardwired to zero, write-through bypass on both read ports.
module riscv_regfile #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumRegs   = 32,
  parameter int unsigned AddrWidth = $clog2(NumRegs)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr1_i,
  input  logic [AddrWidth-1:0] raddr2_i,
  output logic [DataWidth-1:0] rdata1_o,
  output logic [DataWidth-1:0] rdata2_o
);

  logic [DataWidth-1:0] regs_q [NumRegs];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/riscv_decode.sv
// RV32I decode stage: register file read, control decode, immediate expansion, D/E register.
module riscv_decode
  import riscv_decode_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [Xlen-1:0]  i_instr_d,
  input  logic [Xlen-1:0]  i_pc_d,
  input  logic [Xlen-1:0]  i_pc_plus_4d,
  input  logic             i_reg_write_w,
  input  logic [RegAw-1:0] i_rd_w,
  input  logic [Xlen-1:0]  i_result_w,
  input  logic             i_flush_e,
  output logic [RegAw-1:0] o_rs1_d,
  output logic [RegAw-1:0] o_rs2_d,
  output logic [Xlen-1:0]  o_rd1_e,
  output logic [Xlen-1:0]  o_rd2_e,
  output logic [Xlen-1:0]  o_imm_ext_e,
  output logic [Xlen-1:0]  o_pc_e,
  output logic [Xlen-1:0]  o_pc_plus_4e,
  output logic [RegAw-1:0] o_rs1_e,
  output logic [RegAw-1:0] o_rs2_e,
  output logic [RegAw-1:0] o_rd_e,
  output logic             o_reg_write_e,
  output logic             o_mem_write_e,
  output logic             o_jump_e,
  output logic             o_branch_e,
  output logic             o_jalr_e,
  output logic [1:0]       o_result_src_e,
  output logic [1:0]       o_alu_src_a_e,
  output logic             o_alu_src_b_e,
  output logic [3:0]       o_alu_ctrl_e,
  output logic [2:0]       o_funct3_e
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [Xlen-1:0] rd1, rd2;
  ctrl_t           ctrl;
  imm_sel_e        imm_sel;
  de_t             de_d, de_q;

  assign opcode  = i_instr_d[6:0];
  assign funct3  = i_instr_d[14:12];
  assign o_rs1_d = i_instr_d[19:15];
  assign o_rs2_d = i_instr_d[24:20];

  riscv_regfile #(
    .DataWidth(Xlen),
    .NumRegs  (NReg)
  ) u_regfile (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .we_i    (i_reg_write_w),
    .waddr_i (i_rd_w),
    .wdata_i (i_result_w),
    .raddr1_i(o_rs1_d),
    .raddr2_i(o_rs2_d),
    .rdata1_o(rd1),
    .rdata2_o(rd2)
  );

  always_comb begin
    ctrl    = '0;
    imm_sel = ImmI;
    case (opcode)
      OpcLui: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = SrcAZero;
        ctrl.alu_src_b = 1'b1;
        imm_sel        = ImmU;
      end
      OpcAuipc: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = 1'b1;
        imm_sel        = ImmU;
      end
      OpcJal: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.alu_src_a  = SrcAPc;
        ctrl.alu_src_b  = 1'b1;
        imm_sel         = ImmJ;
      end
      OpcJalr: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.alu_src_b  = 1'b1;
      end
      OpcBranch: begin
        ctrl.branch = 1'b1;
        imm_sel     = ImmB;
        case (funct3[2:1])
          2'b10:   ctrl.alu_ctrl = AluSlt;
          2'b11:   ctrl.alu_ctrl = AluSltu;
          default: ctrl.alu_ctrl = AluSub;
        endcase
      end
      OpcLoad: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResMem;
        ctrl.alu_src_b  = 1'b1;
      end
      OpcStore: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_sel        = ImmS;
      end
      OpcOpImm: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct(funct3, i_instr_d[30], 1'b0);
      end
      OpcOp: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct(funct3, i_instr_d[30], 1'b1);
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    de_d           = '0;
    de_d.ctrl      = ctrl;
    de_d.rd1       = rd1;
    de_d.rd2       = rd2;
    de_d.imm       = imm_expand(i_instr_d, imm_sel);
    de_d.pc        = i_pc_d;
    de_d.pc_plus_4 = i_pc_plus_4d;
    de_d.rs1       = o_rs1_d;
    de_d.rs2       = o_rs2_d;
    de_d.rd        = i_instr_d[11:7];
    de_d.funct3    = funct3;
  end

  // A flush inserts a full bubble: data fields are cleared along with the controls.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      de_q <= '0;
    end else if (i_flush_e) begin
      de_q <= '0;
    end else begin
      de_q <= de_d;
    end
  end

  assign o_rd1_e        = de_q.rd1;
  assign o_rd2_e        = de_q.rd2;
  assign o_imm_ext_e    = de_q.imm;
  assign o_pc_e         = de_q.pc;
  assign o_pc_plus_4e   = de_q.pc_plus_4;
  assign o_rs1_e        = de_q.rs1;
  assign o_rs2_e        = de_q.rs2;
  assign o_rd_e         = de_q.rd;
  assign o_reg_write_e  = de_q.ctrl.reg_write;
  assign o_mem_write_e  = de_q.ctrl.mem_write;
  assign o_jump_e       = de_q.ctrl.jump;
  assign o_branch_e     = de_q.ctrl.branch;
  assign o_jalr_e       = de_q.ctrl.jalr;
  assign o_result_src_e = de_q.ctrl.result_src;
  assign o_alu_src_a_e  = de_q.ctrl.alu_src_a;
  assign o_alu_src_b_e  = de_q.ctrl.alu_src_b;
  assign o_alu_ctrl_e   = de_q.ctrl.alu_ctrl;
  assign o_funct3_e     = de_q.funct3;

endmodule
